// File: rtl/seq_tx.sv
// seq_tx: serializes a PAT_W-bit pattern MSB first, rpt copies back to back,
// then pulses done for one cycle. Optional macro SEQ_TX_PARITY_EN appends an
// even-parity bit after every copy.
module seq_tx #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] rpt,
   output logic             dout,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
`ifdef SEQ_TX_PARITY_EN
   localparam logic [1:0] PAR  = 2'd2;
`endif
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state, state_n;
   logic [PAT_W-1:0] shreg, shreg_n;
   logic [PAT_W-1:0] pat_q, pat_n;
   logic [BIT_W-1:0] bitcnt, bitcnt_n;
   logic [CNT_W-1:0] cpycnt, cpycnt_n;
   logic             dout_n, valid_n, busy_n, done_n;

   // Next-state and next-output logic; outputs are registered with the state
   // so they always reflect the state being entered.
   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      pat_n    = pat_q;
      bitcnt_n = bitcnt;
      cpycnt_n = cpycnt;
      dout_n   = 1'b0;
      valid_n  = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               pat_n    = pattern;
               shreg_n  = pattern;
               cpycnt_n = rpt;
               bitcnt_n = '0;
               busy_n   = 1'b1;
               if (rpt != '0) begin
                  state_n = SEND;
                  dout_n  = pattern[PAT_W-1];
                  valid_n = 1'b1;
               end else begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end
         end
         SEND: begin
            if (abort) begin
               state_n = IDLE;
            end else if (bitcnt != BIT_W'(PAT_W-1)) begin
               shreg_n  = {shreg[PAT_W-2:0], 1'b0};
               bitcnt_n = bitcnt + BIT_W'(1);
               dout_n   = shreg[PAT_W-2];
               valid_n  = 1'b1;
               busy_n   = 1'b1;
            end else begin
               // last bit of a copy is on the line; the copy is finished
               cpycnt_n = cpycnt - CNT_W'(1);
               busy_n   = 1'b1;
`ifdef SEQ_TX_PARITY_EN
               state_n  = PAR;
               dout_n   = ^pat_q;
               valid_n  = 1'b1;
`else
               if (cpycnt != CNT_W'(1)) begin
                  state_n  = SEND;
                  shreg_n  = pat_q;
                  bitcnt_n = '0;
                  dout_n   = pat_q[PAT_W-1];
                  valid_n  = 1'b1;
               end else begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
`endif
            end
         end
`ifdef SEQ_TX_PARITY_EN
         PAR: begin
            if (abort) begin
               state_n = IDLE;
            end else if (cpycnt != '0) begin
               state_n  = SEND;
               shreg_n  = pat_q;
               bitcnt_n = '0;
               dout_n   = pat_q[PAT_W-1];
               valid_n  = 1'b1;
               busy_n   = 1'b1;
            end else begin
               state_n = DONE;
               busy_n  = 1'b1;
               done_n  = 1'b1;
            end
         end
`endif
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         shreg  <= '0;
         pat_q  <= '0;
         bitcnt <= '0;
         cpycnt <= '0;
         dout   <= 1'b0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         shreg  <= shreg_n;
         pat_q  <= pat_n;
         bitcnt <= bitcnt_n;
         cpycnt <= cpycnt_n;
         dout   <= dout_n;
         valid  <= valid_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: a frame-level model predicts every cycle's
// outputs; directed frames pin the model with literal bit streams.
module tb_seq_tx;

`ifdef SEQ_TX_PARITY_EN
   localparam int F = 5;
   localparam logic [63:0] EXP_1010_R1 = 64'b10100;
   localparam logic [63:0] EXP_1010_R3 = 64'b101001010010100;
   localparam logic [63:0] EXP_1011_R2 = 64'b1011110111;
   localparam logic [63:0] EXP_ABORT   = 64'b10100101;
`else
   localparam int F = 4;
   localparam logic [63:0] EXP_1010_R1 = 64'b1010;
   localparam logic [63:0] EXP_1010_R3 = 64'b101010101010;
   localparam logic [63:0] EXP_1011_R2 = 64'b10111011;
   localparam logic [63:0] EXP_ABORT   = 64'b1010101;
`endif

   logic       clk, reset, start, abort;
   logic [3:0] pattern;
   logic [7:0] rpt;
   logic       dout, valid, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] cap;
   int          cap_n, done_n;
   logic        f_valid, f_dout, f_done;

   seq_tx #(.PAT_W(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .pattern(pattern), .rpt(rpt),
      .dout(dout), .valid(valid), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame-level model: cur is the expected {dout,valid,busy,done} now,
   // q holds the outputs of the remaining cycles of the frame.
   logic [3:0] cur = 4'b0;
   logic [3:0] q[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         cur <= 4'b0;
      end else if (cur[1]) begin
         if (abort && cur[2]) begin
            q.delete();
            cur <= 4'b0;
         end else if (q.size() > 0) begin
            cur <= q.pop_front();
         end else begin
            cur <= 4'b0;
         end
      end else if (start) begin
         for (int c = 0; c < int'(rpt); c++) begin
            for (int b = 3; b >= 0; b--) q.push_back({pattern[b], 3'b110});
`ifdef SEQ_TX_PARITY_EN
            q.push_back({^pattern, 3'b110});
`endif
         end
         q.push_back(4'b0011);
         cur <= q.pop_front();
      end else begin
         cur <= 4'b0;
      end
   end

   // Per-cycle compare against the model, plus stream capture.
   always @(negedge clk) begin
      n_cmp++;
      if ({dout, valid, busy, done} !== cur) begin
         n_err++;
         $display("FAIL cycle_out t=%0t got dout/valid/busy/done=%b want %b",
                  $time, {dout, valid, busy, done}, cur);
      end
      if (valid === 1'b1) begin
         cap = {cap[62:0], dout};
         cap_n++;
      end
      if (done === 1'b1) done_n++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // Start a frame at the current negedge and run it to idle; while busy,
   // start/pattern/rpt are scrambled to show they are ignored.
   task automatic run_frame(input logic [3:0] p, input logic [7:0] r, input int abort_at);
      int budget;
      bit ended;
      cap = '0; cap_n = 0; done_n = 0; ended = 0;
      pattern = p; rpt = r; start = 1'b1; abort = 1'b0;
      budget = int'(r) * F + 10;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (i == 1) begin
            f_valid = valid; f_dout = dout; f_done = done;
         end
         if (!busy) begin
            ended = 1;
            break;
         end
         abort   = (i == abort_at);
         start   = 1'($urandom);
         pattern = 4'($urandom);
         rpt     = 8'($urandom);
      end
      start = 1'b0;
      abort = 1'b0;
      if (!ended) begin
         n_cmp++;
         n_err++;
         $display("FAIL frame_timeout budget=%0d cycles exceeded", budget);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; rpt = '0;
      cap = '0; cap_n = 0; done_n = 0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 64'({dout, valid, busy, done}), 64'd0);
      reset = 1'b0;

      // single copy, start accepted on the first edge after reset release
      run_frame(4'b1010, 8'd1, -1);
      chk("r1_latency_valid", 64'(f_valid), 64'd1);
      chk("r1_latency_msb", 64'(f_dout), 64'd1);
      chk("r1_bits", cap, EXP_1010_R1);
      chk("r1_count", 64'(cap_n), 64'(F));
      chk("r1_done", 64'(done_n), 64'd1);

      @(negedge clk);
      run_frame(4'b1010, 8'd3, -1);
      chk("r3_bits", cap, EXP_1010_R3);
      chk("r3_count", 64'(cap_n), 64'(3 * F));
      chk("r3_done", 64'(done_n), 64'd1);

      @(negedge clk);
      run_frame(4'b1011, 8'd2, -1);
      chk("p1011_bits", cap, EXP_1011_R2);
      chk("p1011_count", 64'(cap_n), 64'(2 * F));

      @(negedge clk);
      run_frame(4'b0110, 8'd0, -1);
      chk("r0_valid", 64'(cap_n), 64'd0);
      chk("r0_done_next", 64'(f_done), 64'd1);
      chk("r0_done_count", 64'(done_n), 64'd1);

      // abort while the third bit of copy 2 is on the line
      @(negedge clk);
      run_frame(4'b1010, 8'd3, F + 3);
      chk("abort_bits", cap, EXP_ABORT);
      chk("abort_count", 64'(cap_n), 64'(F + 3));
      chk("abort_no_done", 64'(done_n), 64'd0);
      chk("abort_valid_low", 64'(valid), 64'd0);
      @(negedge clk);
      run_frame(4'b1010, 8'd1, -1);
      chk("post_abort_bits", cap, EXP_1010_R1);
      chk("post_abort_done", 64'(done_n), 64'd1);

      // asynchronous reset between edges, mid-copy
      @(negedge clk);
      pattern = 4'b1100; rpt = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0; pattern = 4'b0011;
      @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk("async_reset_out", 64'({dout, valid, busy, done}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_frame(4'b1010, 8'd1, -1);
      chk("post_reset_bits", cap, EXP_1010_R1);
      chk("post_reset_latency", 64'(f_valid), 64'd1);

      // maximum repeat count: no wrap, exactly 255 copies
      @(negedge clk);
      run_frame(4'($urandom), 8'd255, -1);
      chk("max_rpt_count", 64'(cap_n), 64'(255 * F));
      chk("max_rpt_done", 64'(done_n), 64'd1);

      // randomized frames with occasional aborts, checked by the model
      for (int k = 0; k < 40; k++) begin
         logic [7:0] r;
         int ab;
         r  = 8'($urandom_range(0, 5));
         ab = (($urandom % 4) == 0 && r != 0) ? int'($urandom_range(1, int'(r) * F + 1)) : -1;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         run_frame(4'($urandom), r, ab);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
